// File: rtl/lca_pkg.sv
// Shared LM/SM sequencer types: FSM state encoding, write-back select codes and register-list capture.
// Build option LMSM_SKIP_R7_EN masks R7 (the PC) out of every captured register list.
package lca_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    localparam logic [1:0] WB_MEMDATA = 2'b00;
    localparam logic [1:0] WB_ALUOUT  = 2'b01;
    localparam logic [1:0] WB_IMM970  = 2'b10;
    localparam logic [1:0] WB_PCINC   = 2'b11;

    function automatic logic [7:0] capture_list(input logic [7:0] raw);
`ifdef LMSM_SKIP_R7_EN
        return {1'b0, raw[6:0]};
`else
        return raw;
`endif
    endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Decode/memory-side bundle for the LM/SM sequencer; the sequencer uses the slave modport.
interface lmsm_sequencer_if;
    import lca_pkg::*;

    // start is a one-cycle request taken only while busy=0; a transfer (memRead/memWrite,
    // memAddr, regIndex) is held stable until a cycle with memReady=1 and completes on that edge.
    logic        start;
    logic        isStore;
    logic [7:0]  regList;
    logic [15:0] baseAddr;
    logic        memReady;
    logic        busy;
    logic [15:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  regIndex;
    logic        regWrite;
    logic [1:0]  regSelect;
    logic        done;
    state_t      dbg_state;

    modport master (
        output start, isStore, regList, baseAddr, memReady,
        input  busy, memAddr, memRead, memWrite, regIndex, regWrite, regSelect, done, dbg_state
    );

    modport slave (
        input  start, isStore, regList, baseAddr, memReady,
        output busy, memAddr, memRead, memWrite, regIndex, regWrite, regSelect, done, dbg_state
    );

endinterface

// File: rtl/priority_encoder8.sv
// Lowest-set-bit encoder: index of the lowest 1 in in_bits, valid=0 when in_bits is zero.
module priority_encoder8 (
    input  logic [7:0] in_bits,
    output logic [2:0] index,
    output logic       valid
);

    always_comb begin
        index = 3'd0;
        valid = 1'b0;
        // Scanning downward lets the lowest set bit overwrite any higher one.
        for (int i = 7; i >= 0; i--) begin
            if (in_bits[i]) begin
                index = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the register list in ascending order, one memory transfer per register.
// Build option LMSM_SKIP_R7_EN drops R7 from the list at capture (see lca_pkg::capture_list).
module lmsm_sequencer
    import lca_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    lmsm_sequencer_if.slave bus
);

    state_t      state_q, state_d;
    logic [7:0]  pend_q, pend_d;
    logic [15:0] addr_q, addr_d;
    logic        store_q, store_d;

    logic [2:0]  cur_idx;
    logic        cur_valid;
    logic [7:0]  cur_onehot;
    logic [7:0]  remain;
    logic [7:0]  captured;
    logic        in_access;
    logic        reg_write;

    priority_encoder8 u_enc (
        .in_bits (pend_q),
        .index   (cur_idx),
        .valid   (cur_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 8'h00;
            addr_q  <= 16'h0000;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        store_d    = store_q;
        captured   = capture_list(bus.regList);
        cur_onehot = 8'(1) << cur_idx;
        remain     = pend_q & ~cur_onehot;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pend_d  = captured;
                    addr_d  = bus.baseAddr;
                    store_d = bus.isStore;
                    state_d = (captured != 8'h00) ? ST_ACCESS : ST_FINISH;
                end
            end
            ST_ACCESS: begin
                // An empty pending list here is unreachable; leave rather than hang.
                if (!cur_valid) begin
                    state_d = ST_FINISH;
                end else if (bus.memReady) begin
                    pend_d = remain;
                    addr_d = addr_q + 16'd1;
                    if (remain == 8'h00) state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Everything except regWrite/regSelect decodes registered state only.
    always_comb begin
        in_access     = (state_q == ST_ACCESS) && cur_valid;
        reg_write     = in_access && !store_q && bus.memReady;
        bus.busy      = (state_q != ST_IDLE);
        bus.memAddr   = in_access ? addr_q : 16'h0000;
        bus.memRead   = in_access && !store_q;
        bus.memWrite  = in_access && store_q;
        bus.regIndex  = in_access ? cur_idx : 3'd0;
        bus.regWrite  = reg_write;
        bus.regSelect = reg_write ? WB_MEMDATA : WB_ALUOUT;
        bus.done      = (state_q == ST_FINISH);
        bus.dbg_state = state_q;
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: expected transfers {store, regIndex, memAddr} are queued at
// start and popped as each transfer completes; the R7 expectation follows LMSM_SKIP_R7_EN.
module tb_lmsm_sequencer;
    import lca_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic [19:0] exp_q[$];

    lmsm_sequencer_if bus ();

    lmsm_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected summary before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int push_expected(input logic st, input logic [7:0] lst, input logic [15:0] base);
        logic [7:0]  l;
        logic [15:0] a;
        int          n;
        l = lst;
`ifdef LMSM_SKIP_R7_EN
        l[7] = 1'b0;
`endif
        a = base;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (l[i]) begin
                exp_q.push_back({st, 3'(i), a});
                a = a + 16'd1;
                n++;
            end
        end
        return n;
    endfunction

    // One instruction: memReady is held low for the first `stall` cycles of access; `poke` pulses
    // a conflicting start while busy.
    task automatic run_instr(input logic st, input logic [7:0] lst, input logic [15:0] base,
                             input int stall, input bit poke, input string tag);
        int          n;
        int          waits_left;
        int          done_cyc;
        logic        exp_wr;
        logic [19:0] e;
        n          = push_expected(st, lst, base);
        waits_left = stall;
        done_cyc   = 0;
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        bus.start    = 1'b1;
        bus.isStore  = st;
        bus.regList  = lst;
        bus.baseAddr = base;
        bus.memReady = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.start    = poke && (cyc == 1);
            bus.isStore  = !st;
            bus.regList  = 8'($urandom_range(0, 255));
            bus.baseAddr = 16'($urandom_range(0, 65535));
            bus.memReady = (waits_left > 0) ? 1'b0 : 1'b1;
            #1;
            if (bus.done) begin
                done_cyc = cyc;
                check({tag, "_fin_busy"}, 32'(bus.busy), 32'd1);
                check({tag, "_fin_req"}, 32'(bus.memRead | bus.memWrite), 32'd0);
                check({tag, "_fin_regwrite"}, 32'(bus.regWrite), 32'd0);
                check({tag, "_fin_regsel"}, 32'(bus.regSelect), 32'(WB_ALUOUT));
                check({tag, "_fin_state"}, 32'(bus.dbg_state), 32'(ST_FINISH));
                break;
            end
            exp_wr = !st && bus.memReady;
            check({tag, "_req"}, 32'(bus.memRead | bus.memWrite), 32'd1);
            check({tag, "_dir"}, 32'({bus.memWrite, bus.memRead}), 32'({st, !st}));
            check({tag, "_regwrite"}, 32'(bus.regWrite), 32'(exp_wr));
            check({tag, "_regsel"}, 32'(bus.regSelect), exp_wr ? 32'(WB_MEMDATA) : 32'(WB_ALUOUT));
            if (exp_q.size() == 0) begin
                check({tag, "_extra_xfer"}, 32'(exp_q.size()), 32'd1);
            end else begin
                e = bus.memReady ? exp_q.pop_front() : exp_q[0];
                check({tag, "_xfer"}, 32'({bus.memWrite, bus.regIndex, bus.memAddr}), 32'(e));
            end
            if (!bus.memReady) waits_left--;
            @(posedge clk); #1;
        end
        bus.start    = 1'b0;
        bus.memReady = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(n + ((n > 0) ? stall : 0) + 1));
        check({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_post_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.isStore  = 1'b0;
        bus.regList  = 8'h00;
        bus.baseAddr = 16'h0000;
        bus.memReady = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req", 32'({bus.memRead, bus.memWrite, bus.regWrite, bus.done}), 32'd0);
        check("rst_regsel", 32'(bus.regSelect), 32'(WB_ALUOUT));
        check("rst_addr_idx", 32'({bus.memAddr, bus.regIndex}), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        run_instr(1'b0, 8'b1000_0101, 16'h0100, 0, 1'b0, "lm_basic");
        run_instr(1'b1, 8'b0000_0011, 16'h0040, 2, 1'b0, "sm_stall");
        run_instr(1'b0, 8'b0000_0000, 16'h0500, 0, 1'b0, "lm_empty");
        run_instr(1'b1, 8'b0000_0000, 16'h0600, 1, 1'b0, "sm_empty");
        run_instr(1'b0, 8'b0000_0110, 16'hFFFF, 0, 1'b0, "lm_wrap");
        run_instr(1'b1, 8'b0101_0000, 16'h1234, 1, 1'b1, "sm_poke");
        run_instr(1'b0, 8'b1000_0001, 16'h0A00, 0, 1'b0, "lm_r7");
        run_instr(1'b1, 8'b1000_0001, 16'h0B00, 1, 1'b0, "sm_r7");

        // Reset in the middle of an LM, after its first transfer has completed.
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.isStore  = 1'b0;
        bus.regList  = 8'b0000_1110;
        bus.baseAddr = 16'h0200;
        bus.memReady = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1;
        check("mid_first_xfer", 32'({bus.regWrite, bus.regIndex, bus.memAddr}), 32'({1'b1, 3'd1, 16'h0200}));
        @(posedge clk); #1;
        check("mid_second_xfer", 32'({bus.regWrite, bus.regIndex, bus.memAddr}), 32'({1'b1, 3'd2, 16'h0201}));
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_req", 32'({bus.memRead, bus.memWrite, bus.regWrite, bus.done}), 32'd0);
        check("mid_rst_regsel", 32'(bus.regSelect), 32'(WB_ALUOUT));
        check("mid_rst_addr_idx", 32'({bus.memAddr, bus.regIndex}), 32'd0);
        @(posedge clk); #1;
        reset        = 1'b0;
        bus.memReady = 1'b0;
        run_instr(1'b0, 8'b0001_0000, 16'h0300, 0, 1'b0, "after_rst");

        for (int k = 0; k < 4; k++) begin
            run_instr(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)), 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
